// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot or auto-reload terminal count.
// Ports: clk, reset (async, active-low), load/load_value, enable, auto_reload -> q, tc, busy, done.
module down_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q          <= load_value;
        reload_reg <= load_value;
        state      <= (load_value != '0) ? RUN : IDLE;
      end else if (state == RUN && enable) begin
        if (q > WIDTH'(1)) begin
          q <= q - WIDTH'(1);
        end else begin
          // q can only be 1 here: RUN is entered with a nonzero
          // value and auto-reload restores a nonzero value.
          tc <= 1'b1;
          if (auto_reload) begin
            q <= reload_reg;
          end else begin
            q     <= '0;
            state <= DONE;
          end
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
